// File: rtl/crc_pkg.sv
// Shared constants, state type and bit-transpose helper for the multi-cycle CRC engine.
package crc_pkg;

  // Register offsets from the window base
  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_GPOLY  = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
  localparam logic [31:0] OFF_FXOR   = 32'h0000_000C;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

  // CTRL bit positions
  localparam int CTRL_TOT_MSB  = 31;
  localparam int CTRL_TOT_LSB  = 30;
  localparam int CTRL_TOTR_MSB = 29;
  localparam int CTRL_TOTR_LSB = 28;
  localparam int CTRL_FXOR     = 26;
  localparam int CTRL_WAS      = 25;
  localparam int CTRL_TCRC     = 24;

  // Reset values and the unmapped-read pattern
  localparam logic [31:0] RST_SEED     = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_GPOLY    = 32'h0000_1021;
  localparam logic [31:0] RST_CTRL     = 32'h0000_0000;
  localparam logic [31:0] RST_FXOR     = 32'hFFFF_FFFF;
  localparam logic [31:0] UNMAPPED_VAL = 32'h1234_5678;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  // 00 none, 01 reverse bits inside each byte, 10 full reverse, 11 byte swap
  function automatic logic [31:0] transpose(input logic [1:0] mode, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    case (mode)
      2'b01: begin
        for (int b = 0; b < 4; b++) begin
          for (int j = 0; j < 8; j++) begin
            r[8*b + j] = v[8*b + 7 - j];
          end
        end
      end
      2'b10: begin
        for (int i = 0; i < 32; i++) begin
          r[i] = v[31 - i];
        end
      end
      2'b11: r = {v[7:0], v[15:8], v[23:16], v[31:24]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Unrolled BPC-step CRC datapath: consumes BPC message bits MSB-first per call.
module crc_step
  import crc_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic [31:0] crc,
  input  logic [31:0] din,
  input  logic [31:0] gpoly,
  input  logic        tcrc,
  output logic [31:0] crc_next,
  output logic [31:0] din_next
);

  logic [31:0] c;
  logic [31:0] d;
  logic        fb;
  logic [31:0] poly_w;

  // Chain BPC single-bit steps; in 16-bit mode the upper half is held at zero
  always_comb begin
    c      = crc;
    d      = din;
    fb     = 1'b0;
    poly_w = tcrc ? gpoly : {16'h0000, gpoly[15:0]};
    for (int i = 0; i < BPC; i++) begin
      fb = tcrc ? c[31] : c[15];
      c  = {c[30:0], d[31]};
      if (!tcrc) c[31:16] = 16'h0000;
      if (fb) c = c ^ poly_w;
      d  = {d[30:0], 1'b0};
    end
    crc_next = c;
    din_next = d;
  end

endmodule

// File: rtl/crc_engine_mc.sv
// Multi-cycle memory-mapped CRC engine: register file, FSM, bus wait states, result path.
// Bus handshake: an access is taken at a clock edge where sel & ready are both 1;
// while ready is 0 the master must hold sel/rw/addr/data_wr unchanged.
module crc_engine_mc
  import crc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
  parameter int          MAX_W     = 32,
  parameter int          BPC       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        ready,
  output logic        busy,
  output logic        done
);

  localparam int             N_CYC = 32 / BPC;
  localparam int             CW    = 6;
  localparam logic [CW-1:0]  LAST  = CW'(N_CYC - 1);

  crc_state_e    state_q, state_d;
  logic [31:0]   seed_q, gpoly_q, ctrl_q, fxor_q;
  logic [31:0]   crc_q, din_q;
  logic [31:0]   crc_nx, din_nx;
  logic [CW-1:0] cnt_q;
  logic          overflow_q, stall_q;

  logic          hit_data, hit_gpoly, hit_ctrl, hit_fxor, hit_status;
  logic          wr, start, tcrc;
  logic [1:0]    tot, totr;
  logic [31:0]   data_in_t, ctrl_wval, mask, fx, result;

  assign hit_data   = (addr == BASE_ADDR + OFF_DATA);
  assign hit_gpoly  = (addr == BASE_ADDR + OFF_GPOLY);
  assign hit_ctrl   = (addr == BASE_ADDR + OFF_CTRL);
  assign hit_fxor   = (addr == BASE_ADDR + OFF_FXOR);
  assign hit_status = (addr == BASE_ADDR + OFF_STATUS);

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  // Writes and DATA reads wait while the engine runs; other reads go straight through
  assign ready = !(busy && sel && (rw || hit_data));
  assign wr    = sel && ready && rw;

  // A 16-bit-only build never lets TCRC become 1
  assign tcrc      = (MAX_W == 32) ? ctrl_q[CTRL_TCRC] : 1'b0;
  assign ctrl_wval = (MAX_W == 32) ? data_wr : (data_wr & ~(32'h1 << CTRL_TCRC));
  assign tot       = ctrl_q[CTRL_TOT_MSB:CTRL_TOT_LSB];
  assign totr      = ctrl_q[CTRL_TOTR_MSB:CTRL_TOTR_LSB];
  assign data_in_t = transpose(tot, data_wr);
  assign start     = wr && hit_data && !ctrl_q[CTRL_WAS];

  crc_step #(.BPC(BPC)) u_step (
    .crc      (crc_q),
    .din      (din_q),
    .gpoly    (gpoly_q),
    .tcrc     (tcrc),
    .crc_next (crc_nx),
    .din_next (din_nx)
  );

  // Next-state logic: IDLE -> SHIFT on start, SHIFT for N_CYC cycles, one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Register file; the seed is loaded by WAS writes and by the DONE commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q  <= RST_SEED;
      gpoly_q <= RST_GPOLY;
      ctrl_q  <= RST_CTRL;
      fxor_q  <= RST_FXOR;
    end else begin
      if (wr && hit_gpoly) gpoly_q <= data_wr;
      if (wr && hit_ctrl)  ctrl_q  <= ctrl_wval;
      if (wr && hit_fxor)  fxor_q  <= data_wr;
      if (state_q == DONE)
        seed_q <= crc_q;
      else if (wr && hit_data && ctrl_q[CTRL_WAS])
        seed_q <= data_in_t;
    end
  end

  // Shift datapath and step counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= '0;
      din_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        din_q <= data_in_t;
        crc_q <= tcrc ? seed_q : {16'h0000, seed_q[15:0]};
        cnt_q <= '0;
      end
    end else if (state_q == SHIFT) begin
      crc_q <= crc_nx;
      din_q <= din_nx;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Sticky overflow: master abandoned a stalled access by dropping sel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stall_q <= sel && !ready;
      if (stall_q && !sel) overflow_q <= 1'b1;
    end
  end

  // Result path: optional final XOR, then output transpose
  always_comb begin
    if (tcrc)          mask = fxor_q;
    else if (totr[1])  mask = {fxor_q[15:0], 16'h0000};
    else               mask = {16'h0000, fxor_q[15:0]};
    fx     = seed_q ^ (ctrl_q[CTRL_FXOR] ? mask : 32'h0);
    result = transpose(totr, fx);
  end

  // Read mux
  always_comb begin
    data_rd = UNMAPPED_VAL;
    if (hit_data)        data_rd = result;
    else if (hit_gpoly)  data_rd = gpoly_q;
    else if (hit_ctrl)   data_rd = ctrl_q;
    else if (hit_fxor)   data_rd = fxor_q;
    else if (hit_status) data_rd = {30'h0, overflow_q, busy};
  end

endmodule

// File: tb/tb_crc_engine_mc.sv
// Bench for crc_engine_mc: three instances (BPC 1, 4, 32) on a shared bus, one selected at a time.
module tb_crc_engine_mc;

  localparam logic [31:0] BASE = 32'h4003_2000;
  localparam logic [31:0] A_DATA = BASE + 32'h00;
  localparam logic [31:0] A_GPOLY = BASE + 32'h04;
  localparam logic [31:0] A_CTRL = BASE + 32'h08;
  localparam logic [31:0] A_FXOR = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel_v;
  logic        rw;
  logic [31:0] addr, data_wr;
  logic [31:0] data_rd_v [3];
  logic [2:0]  ready_v, busy_v, done_v;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      crc_engine_mc #(
        .BASE_ADDR (BASE),
        .MAX_W     (32),
        .BPC       ((g == 0) ? 1 : ((g == 1) ? 4 : 32))
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel_v[g]),
        .rw      (rw),
        .addr    (addr),
        .data_wr (data_wr),
        .data_rd (data_rd_v[g]),
        .ready   (ready_v[g]),
        .busy    (busy_v[g]),
        .done    (done_v[g])
      );
    end
  endgenerate

  int cur   = 1;
  int n_cyc = 8;
  int checks = 0;
  int passed = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  // ---------------- reference model ----------------
  logic [31:0] m_seed, m_poly, m_ctrl, m_fxor;

  function automatic int bpc_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 32);
  endfunction

  function automatic logic [31:0] t_model(logic [1:0] mode, logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 32; i++) begin
      if (mode == 2'b01) r[i] = v[i ^ 7];
      if (mode == 2'b10) r[i] = v[31 - i];
      if (mode == 2'b11) r[i] = v[i ^ 24];
    end
    return r;
  endfunction

  // Bit-serial CRC of one 32-bit word, MSB first, width 16 or 32
  function automatic logic [31:0] crc_model(logic [31:0] seed, logic [31:0] msg,
                                            logic [31:0] poly, logic wide);
    logic [31:0] wmask, c;
    int          w;
    logic        fb;
    w     = wide ? 32 : 16;
    wmask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    c     = seed & wmask;
    for (int b = 31; b >= 0; b--) begin
      fb = c[w-1];
      c  = ((c << 1) | {31'h0, msg[b]}) & wmask;
      if (fb) c = c ^ (poly & wmask);
    end
    return c;
  endfunction

  function automatic logic [31:0] result_model();
    logic [31:0] mask;
    if (m_ctrl[24])      mask = m_fxor;
    else if (m_ctrl[29]) mask = {m_fxor[15:0], 16'h0};
    else                 mask = {16'h0, m_fxor[15:0]};
    return t_model(m_ctrl[29:28], m_seed ^ (m_ctrl[26] ? mask : 32'h0));
  endfunction

  function automatic void m_reset();
    m_seed = 32'hFFFF_FFFF;
    m_poly = 32'h0000_1021;
    m_ctrl = 32'h0;
    m_fxor = 32'hFFFF_FFFF;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every completed read is compared with the oldest expectation
  always @(negedge clk) begin
    logic [31:0] e;
    string       nm;
    if (rst_n === 1'b1 && sel_v[cur] && ready_v[cur] && !rw) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read: got %h, expected no read", data_rd_v[cur]);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, data_rd_v[cur], e);
      end
    end
  end

  // ---------------- driver tasks (start and end #1 after posedge) ----------------
  task automatic handshake(output int stalls);
    int guard;
    stalls = 0;
    guard  = 0;
    @(negedge clk);
    while (!ready_v[cur] && guard < 200) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (!ready_v[cur]) begin
      checks++;
      $display("FAIL handshake_timeout: got ready=0 after %0d cycles, expected ready=1", guard);
    end
    @(posedge clk);
    #1;
    sel_v = '0;
    rw    = 1'b0;
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d, output int stalls);
    sel_v      = '0;
    sel_v[cur] = 1'b1;
    rw         = 1'b1;
    addr       = a;
    data_wr    = d;
    handshake(stalls);
  endtask

  task automatic bus_read(logic [31:0] a, logic [31:0] e, string nm, output int stalls);
    exp_q.push_back(e);
    name_q.push_back(nm);
    sel_v      = '0;
    sel_v[cur] = 1'b1;
    rw         = 1'b0;
    addr       = a;
    handshake(stalls);
    if (!ready_v[cur] && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic reg_write(logic [31:0] a, logic [31:0] d);
    int st;
    bus_write(a, d, st);
    if (a == A_GPOLY) m_poly = d;
    if (a == A_CTRL)  m_ctrl = d;
    if (a == A_FXOR)  m_fxor = d;
  endtask

  // DATA write; when timed, checks busy at T+1 and the single done pulse at T+N+1
  task automatic data_start(logic [31:0] d, bit timed, output int stalls);
    logic [31:0] dt;
    int          first, dones;
    dt = t_model(m_ctrl[31:30], d);
    if (m_ctrl[25]) m_seed = dt;
    else            m_seed = crc_model(m_seed, dt, m_poly, m_ctrl[24]);
    bus_write(A_DATA, d, stalls);
    if (timed && !m_ctrl[25]) begin
      first = 0;
      dones = 0;
      for (int k = 1; k <= n_cyc + 1; k++) begin
        @(negedge clk);
        if (k == 1) check("busy_after_start", {31'h0, busy_v[cur]}, 32'h1);
        if (done_v[cur]) begin
          dones++;
          if (first == 0) first = k;
        end
      end
      check("done_cycle", 32'(first), 32'(n_cyc + 1));
      check("done_pulses", 32'(dones), 32'h1);
    end
  endtask

  // Read DATA in the next cycle; it must complete without a wait state
  task automatic read_data(string nm, logic [31:0] e);
    int st;
    @(posedge clk);
    #1;
    bus_read(A_DATA, e, nm, st);
    check({nm, "_latency"}, 32'(st), 32'h0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_v[cur] && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (busy_v[cur]) begin
      checks++;
      $display("FAIL idle_timeout: got busy=1, expected busy=0");
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with a GPOLY write presented on every instance; it must be ignored
  task automatic do_reset();
    rst_n   = 1'b0;
    sel_v   = 3'b111;
    rw      = 1'b1;
    addr    = A_GPOLY;
    data_wr = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    sel_v = '0;
    rw    = 1'b0;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic select(int i);
    cur   = i;
    n_cyc = 32 / bpc_of(i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, st2, dones;
    logic [31:0] rnd;
    sel_v = '0; rw = 1'b0; addr = '0; data_wr = '0; rst_n = 1'b0;
    m_reset();

    // Reset state
    select(1);
    do_reset();
    check("ready_rst", {31'h0, ready_v[cur]}, 32'h1);
    check("busy_rst", {31'h0, busy_v[cur]}, 32'h0);
    check("done_rst", {31'h0, done_v[cur]}, 32'h0);
    bus_read(A_DATA, 32'hFFFF_FFFF, "rst_data", st);
    bus_read(A_GPOLY, 32'h0000_1021, "rst_gpoly", st);
    bus_read(A_CTRL, 32'h0000_0000, "rst_ctrl", st);
    bus_read(A_FXOR, 32'hFFFF_FFFF, "rst_fxor", st);
    bus_read(A_STATUS, 32'h0000_0000, "rst_status", st);
    bus_read(BASE + 32'h14, 32'h1234_5678, "unmapped", st);

    // Directed 16-bit and 32-bit paths on every BPC
    for (int i = 0; i < 3; i++) begin
      select(i);
      do_reset();
      reg_write(A_CTRL, 32'h0200_0000);
      data_start(32'h0, 1'b0, st);
      reg_write(A_CTRL, 32'h0000_0000);
      data_start(32'h0000_0001, 1'b1, st);
      read_data("crc16_plain", 32'h0000_0001);
      reg_write(A_CTRL, 32'h0400_0000);
      read_data("crc16_fxor", 32'h0000_FFFE);
      reg_write(A_CTRL, 32'h2000_0000);
      read_data("crc16_totr", 32'h8000_0000);

      reg_write(A_GPOLY, 32'h04C1_1DB7);
      reg_write(A_CTRL, 32'h0300_0000);
      data_start(32'h0000_0001, 1'b0, st);
      reg_write(A_CTRL, 32'h0100_0000);
      data_start(32'h0, 1'b1, st);
      read_data("crc32_fb", 32'h04C1_1DB7);
    end

    // Back-to-back DATA writes: second stalls N+1 cycles
    for (int i = 0; i < 3; i++) begin
      select(i);
      do_reset();
      reg_write(A_CTRL, 32'h0100_0000);
      reg_write(A_GPOLY, 32'h04C1_1DB7);
      data_start($urandom, 1'b0, st);
      data_start($urandom, 1'b1, st2);
      check("stall_cycles", 32'(st2), 32'(n_cyc + 1));
      read_data("b2b_result", result_model());
    end

    // Status readable while busy, then reset mid-SHIFT discards the run
    select(1);
    do_reset();
    data_start(32'hA5A5_5A5A, 1'b0, st);
    bus_read(A_STATUS, 32'h0000_0001, "status_busy", st);
    check("status_busy_latency", 32'(st), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    dones = 0;
    for (int k = 0; k < n_cyc + 3; k++) begin
      @(negedge clk);
      if (done_v[cur]) dones++;
    end
    check("midreset_done", 32'(dones), 32'h0);
    read_data("midreset_data", 32'hFFFF_FFFF);

    // Dropping sel during a stall sets sticky overflow
    data_start(32'h1234_0000, 1'b0, st);
    sel_v[cur] = 1'b1;
    rw         = 1'b1;
    addr       = A_DATA;
    data_wr    = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    sel_v = '0;
    rw    = 1'b0;
    wait_idle();
    bus_read(A_STATUS, 32'h0000_0002, "overflow_set", st);
    read_data("overflow_data", result_model());
    do_reset();
    bus_read(A_STATUS, 32'h0000_0000, "overflow_clr", st);

    // Randomized sweep over BPC 1, 4, 32
    for (int i = 0; i < 3; i++) begin
      select(i);
      do_reset();
      for (int it = 0; it < 6; it++) begin
        rnd = $urandom;
        reg_write(A_GPOLY, rnd | 32'h1);
        reg_write(A_FXOR, $urandom);
        rnd = $urandom;
        reg_write(A_CTRL, {rnd[31:30], 4'b0010, rnd[24], 24'h0});
        data_start($urandom, 1'b0, st);
        rnd = $urandom;
        reg_write(A_CTRL, {rnd[31:28], 1'b0, rnd[26], 1'b0, m_ctrl[24], 24'h0});
        data_start($urandom, 1'b1, st);
        read_data("sweep_result", result_model());
        bus_read(A_GPOLY, m_poly, "sweep_gpoly", st);
      end
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
